pc_fetch_sequencer: RTL and testbench

Sequential fetch controller for the RV32 core. It owns the program counter and issues instruction-memory requests over a req/ready + rvalid handshake. It presents each fetched instruction to decode with a valid/stall handshake and advances the PC by 4 modulo 2^32. It also applies branch/jump redirects and trap entry with fixed priority.

---
 rtl/pc_fetch_sequencer.sv | 179 +++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Sequential instruction-fetch controller for the RV32 core. It owns the
// program counter. It issues one instruction-memory request at a time over a
// req/ready + rvalid handshake. Each returned word goes to decode through a
// valid/stall handshake. Branch/jump redirects and trap entry override
// sequential PC advance with fixed priority: trap > redirect > pc+4.
//
// Build option:
//   PC_SEQ_MISALIGN_TRAP_EN  when defined, a redirect whose target has
//                            [1:0] != 0 vectors to TRAP_VECTOR and pulses
//                            misalign_err. When undefined, the low two
//                            target bits are cleared and misalign_err is 0.
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   rst_n          in   asynchronous active-low reset
//   imem_req       out  fetch request (high in FETCH)
//   imem_addr      out  fetch address, always the current PC
//   imem_ready     in   request accepted when imem_req && imem_ready
//   imem_rvalid    in   read data valid (honoured only while waiting)
//   imem_rdata     in   instruction word
//   instr_valid    out  instr/instr_pc hold a valid instruction
//   instr          out  fetched instruction
//   instr_pc       out  address of instr
//   stall          in   decode not ready; consume on instr_valid && !stall
//   redirect_valid in   branch/jump taken this cycle
//   redirect_pc    in   redirect target
//   trap           in   trap entry request
//   misalign_err   out  one-cycle pulse on a misaligned redirect target
// -----------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap,
    output logic        misalign_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        WAIT_RESP = 2'd1,
        HOLD      = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        discard_q, discard_d;

    logic        redir_any;
    logic        consume;
    logic [31:0] redir_target;

    assign redir_any = trap || redirect_valid;
    assign consume   = (state_q == HOLD) && !stall;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    logic tgt_misaligned;

    assign tgt_misaligned = |redirect_pc[1:0];
    // A trap on the same cycle suppresses the redirect, so no error is flagged.
    assign misalign_d     = redirect_valid && !trap && tgt_misaligned;
    assign redir_target   = (trap || tgt_misaligned) ? TRAP_VECTOR : redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_err = misalign_q;
`else
    logic [1:0] unused_redirect_lsbs;

    assign unused_redirect_lsbs = redirect_pc[1:0];
    assign redir_target         = trap ? TRAP_VECTOR : {redirect_pc[31:2], 2'b00};
    assign misalign_err         = 1'b0;
`endif

    // Next PC: trap/redirect always win, including over a same-edge consume.
    always_comb begin
        pc_d = pc_q;
        if (redir_any) begin
            pc_d = redir_target;
        end else if (consume) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    state_d = WAIT_RESP;
                    // The accepted request was for the old PC; its data is stale.
                    if (redir_any) begin
                        discard_d = 1'b1;
                    end
                end
            end
            WAIT_RESP: begin
                if (imem_rvalid) begin
                    if (discard_q || redir_any) begin
                        discard_d = 1'b0;
                        state_d   = FETCH;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        state_d    = HOLD;
                    end
                end else if (redir_any) begin
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (redir_any || !stall) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d   = FETCH;
                discard_d = 1'b0;
            end
        endcase
        instr_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= NOP;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            discard_q     <= discard_d;
        end
    end

    // Gated by rst_n so the request is low while reset is held.
    assign imem_req    = (state_q == FETCH) && rst_n;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
`timescale 1ns/1ps
module tb_pc_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap;
    logic        misalign_err;

    pc_fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap           (trap),
        .misalign_err   (misalign_err)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fetch_cyc = 0;
    int   prev_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in FETCH with the expected address; returns sampled in HOLD.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data);
        exp_t e;
        fetch_cyc = cyc;
        imem_ready = 1'b1;
        chk1("fetch_req", imem_req, 1'b1);
        chk32("fetch_addr", imem_addr, exp_addr);
        step();
        chk1("wait_req_low", imem_req, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        sb.push_back('{pc: exp_addr, data: data});
        step();
        imem_rvalid = 1'b0;
        chk1("hold_valid", instr_valid, 1'b1);
        chk1("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk32("hold_instr", instr, e.data);
            chk32("hold_instr_pc", instr_pc, e.pc);
        end
    endtask

    initial begin
        rst_n          = 1'b1;
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        trap           = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk1("rst_req", imem_req, 1'b0);
        chk32("rst_addr", imem_addr, 32'h0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk32("rst_instr", instr, 32'h0000_0013);
        chk32("rst_instr_pc", instr_pc, 32'h0);
        chk1("rst_misalign", misalign_err, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        #1;

        // Sequential fetch, one instruction every three cycles
        do_fetch(32'h0, 32'h1111_0001);
        prev_cyc = fetch_cyc;
        step();
        do_fetch(32'h4, 32'h2222_0002);
        chk32("throughput_0_4", 32'(fetch_cyc - prev_cyc), 32'd3);
        prev_cyc = fetch_cyc;
        step();
        do_fetch(32'h8, 32'h0050_0093);
        chk32("throughput_4_8", 32'(fetch_cyc - prev_cyc), 32'd3);

        // Stall holds the instruction in place
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("stall_valid", instr_valid, 1'b1);
            chk32("stall_instr", instr, 32'h0050_0093);
            chk32("stall_instr_pc", instr_pc, 32'h8);
            chk1("stall_no_req", imem_req, 1'b0);
        end
        stall = 1'b0;
        step();
        do_fetch(32'hC, 32'h3333_0003);
        step();

        // Redirect while waiting for the response
        chk32("pre_redir_addr", imem_addr, 32'h10);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        chk1("redir_wait_req", imem_req, 1'b0);
        chk32("redir_wait_addr", imem_addr, 32'h200);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk1("redir_dropped", instr_valid, 1'b0);
        chk1("redir_req", imem_req, 1'b1);
        chk32("redir_addr", imem_addr, 32'h200);

        // Trap beats redirect
        imem_ready     = 1'b0;
        trap           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        trap           = 1'b0;
        redirect_valid = 1'b0;
        do_fetch(32'h100, 32'h4444_0004);

        // Redirect in HOLD wins over same-edge consume
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk1("hold_redir_valid", instr_valid, 1'b0);

        // Wraparound
        do_fetch(32'hFFFF_FFFC, 32'h5555_0005);
        step();
        do_fetch(32'h0, 32'h6666_0006);
        step();
        chk32("wrap_next_addr", imem_addr, 32'h4);
        step();

        // Asynchronous reset in WAIT_RESP
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_req", imem_req, 1'b0);
        chk32("arst_addr", imem_addr, 32'h0);
        chk1("arst_valid", instr_valid, 1'b0);
        chk32("arst_instr", instr, 32'h0000_0013);
        chk32("arst_instr_pc", instr_pc, 32'h0);
        step();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        rst_n       = 1'b1;
        step();
        imem_rvalid = 1'b0;
        chk1("late_rvalid_valid", instr_valid, 1'b0);
        chk32("late_rvalid_instr", instr, 32'h0000_0013);
        chk1("late_rvalid_req", imem_req, 1'b1);
        chk32("late_rvalid_addr", imem_addr, 32'h0);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h202;
        step();
        redirect_valid = 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        chk1("misalign_pulse", misalign_err, 1'b1);
        chk32("misalign_addr", imem_addr, 32'h100);
`else
        chk1("misalign_pulse", misalign_err, 1'b0);
        chk32("misalign_addr", imem_addr, 32'h200);
`endif
        step();
        chk1("misalign_cleared", misalign_err, 1'b0);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        do_fetch(32'h100, 32'h7777_0007);
`else
        do_fetch(32'h200, 32'h7777_0007);
`endif
        step();
        chk1("sb_drained", sb.size() == 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
